mux_arbiter4: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 18 +
 rtl/rr_pick4.sv | 27 ++
 rtl/mux_arbiter4.sv | 123 ++++++++++++
 tb/tb_mux_arbiter4.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-requester mux arbiter.
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int SEL_W = 2;

   typedef enum logic {IDLE, BUSY} arb_state_t;
   typedef logic [N_REQ-1:0] req_vec_t;
   typedef logic [SEL_W-1:0] sel_t;

   function automatic req_vec_t onehot(input sel_t idx);
      req_vec_t vec;
      vec      = '0;
      vec[idx] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ptr+3, ptr and
// returns the first asserted request.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  req_vec_t req,
   input  sel_t     ptr,
   output sel_t     winner,
   output logic     any
);

   sel_t idx;

   always_comb begin
      winner = ptr;
      any    = 1'b0;
      idx    = ptr;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = ptr + SEL_W'(k);
         if (!any && req[idx]) begin
            winner = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arbiter4.sv
// Round-robin arbiter owning the select lines of a shared 4:1 mux, with a
// bounded hold that forces rotation when other requesters are waiting.
module mux_arbiter4
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [SEL_W-1:0] selection,
   output logic             valid
);

   // valid marks ownership: while valid is high, grant is one-hot and
   // selection drives the mux. There is no ready; a requester keeps req high
   // until its grant bit appears and drops it to release the mux.

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   arb_state_t       state, state_nxt;
   sel_t             last, last_nxt;
   logic [7:0]       hold_cnt, hold_nxt;
   logic [N_REQ-1:0] grant_nxt;
   sel_t             sel_nxt;
   logic             valid_nxt;

   logic             owner_req;
   logic             others_any;
   logic             at_limit;
   logic             rotate;
   logic             take_new;
   req_vec_t         pick_req;
   sel_t             win;
   logic             win_any;

   assign owner_req  = req[selection];
   assign others_any = |(req & ~grant);
   assign at_limit   = (hold_cnt >= HOLD_LAST);
   assign rotate     = (state == BUSY) && owner_req && others_any && at_limit;
   // A forced rotation must skip the still-requesting owner.
   assign pick_req   = rotate ? (req & ~grant) : req;

   rr_pick4 u_pick (
      .req    (pick_req),
      .ptr    (last),
      .winner (win),
      .any    (win_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         last      <= 2'd3;
         hold_cnt  <= '0;
         grant     <= '0;
         selection <= '0;
         valid     <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         hold_cnt  <= hold_nxt;
         grant     <= grant_nxt;
         selection <= sel_nxt;
         valid     <= valid_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|req) state_nxt = BUSY;
         BUSY:    if (req == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      grant_nxt = grant;
      sel_nxt   = selection;
      valid_nxt = valid;
      last_nxt  = last;
      hold_nxt  = hold_cnt;
      take_new  = 1'b0;
      case (state)
         IDLE: begin
            if (win_any) begin
               take_new = 1'b1;
            end else begin
               grant_nxt = '0;
               valid_nxt = 1'b0;
               hold_nxt  = '0;
            end
         end
         BUSY: begin
            if (req == '0) begin
               grant_nxt = '0;
               valid_nxt = 1'b0;
               hold_nxt  = '0;
            end else if (!owner_req || rotate) begin
               take_new = 1'b1;
            end else if (!at_limit) begin
               // Counts while alone too, saturating at the last allowed cycle.
               hold_nxt = hold_cnt + 8'd1;
            end
         end
         default: begin
            grant_nxt = '0;
            valid_nxt = 1'b0;
         end
      endcase
      if (take_new) begin
         grant_nxt = onehot(win);
         sel_nxt   = win;
         valid_nxt = 1'b1;
         last_nxt  = win;
         hold_nxt  = '0;
      end
   end

endmodule

// File: tb/tb_mux_arbiter4.sv
// Scoreboard bench for mux_arbiter4: directed vectors, a MAX_HOLD=1 instance
// and a long random run checking invariants and the fairness bound.
module tb_mux_arbiter4;

   localparam int MAX_HOLD   = 8;
   localparam int WAIT_BOUND = 3 * MAX_HOLD + 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] req   = 4'b1111;
   logic [3:0] req1  = 4'b0000;
   logic [3:0] grant, grant1;
   logic [1:0] selection, selection1;
   logic       valid, valid1;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [6:0] exp_q[$];
   int         due_q[$];
   logic [6:0] m_exp;
   int         m_due;

   mux_arbiter4 #(.MAX_HOLD(MAX_HOLD)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .grant     (grant),
      .selection (selection),
      .valid     (valid)
   );

   mux_arbiter4 #(.MAX_HOLD(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req1),
      .grant     (grant1),
      .selection (selection1),
      .valid     (valid1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                       input logic ev);
      @(posedge clk);
      #1;
      req = r;
      exp_q.push_back({eg, es, ev});
      due_q.push_back(cyc + 1);
   endtask

   // Monitor: pops every expectation whose sampling edge has just passed.
   always @(posedge clk) begin
      #2;
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
         m_due = due_q.pop_front();
         m_exp = exp_q.pop_front();
         check("sb_grant", {28'd0, grant}, {28'd0, m_exp[6:3]});
         check("sb_selection", {30'd0, selection}, {30'd0, m_exp[2:1]});
         check("sb_valid", {31'd0, valid}, {31'd0, m_exp[0]});
      end
   end

   initial begin
      logic [3:0] prev;
      logic [3:0] nr;
      logic [3:0] sel_hot;
      int         w[4];

      // Reset block
      #1 rst_n = 1'b0;
      #1;
      check("rst_grant", {28'd0, grant}, 32'd0);
      check("rst_selection", {30'd0, selection}, 32'd0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_grant1", {28'd0, grant1}, 32'd0);
      repeat (2) @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.push_back({4'b0001, 2'd0, 1'b1});
      due_q.push_back(cyc + 1);

      // Asynchronous reset while requester 0 owns the mux
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_grant", {28'd0, grant}, 32'd0);
      check("async_selection", {30'd0, selection}, 32'd0);
      check("async_valid", {31'd0, valid}, 32'd0);
      req = 4'b0000;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Lone requester 2 holds the mux, then releases
      repeat (20) step(4'b0100, 4'b0100, 2'd2, 1'b1);
      step(4'b0000, 4'b0000, 2'd2, 1'b0);

      // Pointer at 2: round-robin order 3, 0, 2
      step(4'b1101, 4'b1000, 2'd3, 1'b1);
      step(4'b0101, 4'b0001, 2'd0, 1'b1);
      step(4'b0100, 4'b0100, 2'd2, 1'b1);
      step(4'b0000, 4'b0000, 2'd2, 1'b0);

      // Owner 1 releases as requester 3 arrives: no idle bubble
      step(4'b0010, 4'b0010, 2'd1, 1'b1);
      step(4'b1000, 4'b1000, 2'd3, 1'b1);
      step(4'b0000, 4'b0000, 2'd3, 1'b0);

      // Two constant requesters alternate every MAX_HOLD cycles
      for (int n = 0; n < 32; n++) begin
         if (((n / MAX_HOLD) % 2) == 0) step(4'b0011, 4'b0001, 2'd0, 1'b1);
         else                           step(4'b0011, 4'b0010, 2'd1, 1'b1);
      end
      step(4'b0000, 4'b0000, 2'd1, 1'b0);
      repeat (3) @(posedge clk);

      // MAX_HOLD=1 instance yields every cycle
      @(posedge clk);
      #1 req1 = 4'b0011;
      for (int n = 0; n < 8; n++) begin
         @(posedge clk);
         #2;
         check("hold1_grant", {28'd0, grant1}, (n % 2 == 0) ? 32'h1 : 32'h2);
         check("hold1_valid", {31'd0, valid1}, 32'd1);
      end
      req1 = 4'b0000;

      // Random run: invariants and fairness bound
      prev = 4'b0000;
      req  = 4'b0000;
      for (int i = 0; i < 4; i++) w[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         @(posedge clk);
         #2;
         if (c > 0) begin
            check("rnd_onehot0", {31'd0, ($countones(grant) <= 1)}, 32'd1);
            check("rnd_valid", {31'd0, valid}, {31'd0, |grant});
            if (valid) begin
               sel_hot = 4'b0001 << selection;
               check("rnd_sel_match", {28'd0, grant}, {28'd0, sel_hot});
               check("rnd_grant_req", {31'd0, |(grant & prev)}, 32'd1);
            end
            for (int i = 0; i < 4; i++) begin
               if (prev[i] && !grant[i]) w[i]++;
               else                      w[i] = 0;
               if (prev[i]) check($sformatf("rnd_wait%0d_le_bound", i),
                                  {31'd0, (w[i] <= WAIT_BOUND)}, 32'd1);
            end
         end
         nr = prev;
         for (int i = 0; i < 4; i++) begin
            if (prev[i] && grant[i] && $urandom_range(0, 5) == 0) nr[i] = 1'b0;
            else if (!prev[i] && $urandom_range(0, 3) == 0)       nr[i] = 1'b1;
         end
         if ($urandom_range(0, 199) == 0) nr = 4'b0000;
         req  = nr;
         prev = nr;
      end
      req = 4'b0000;
      repeat (3) @(posedge clk);
      #3;

      // Final report
      check("queue_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
